pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Generic, parametrised valid/ready pipeline stage buffer.
- Supersedes the per-stage fixed-field stage registers (F/D/E/M/W). Each pipeline boundary instantiates it with its concatenated payload width.
- Provides a DEPTH-entry in-order queue, full throughput when DEPTH>=2, a synchronous flush for branch/trap redirect, and an occupancy output.
- Sits between a producer stage (s_*) and a consumer stage (m_*).

Parameters:
- DW, 32, payload width in bits (>=1).
- DEPTH, 2, number of storage entries (1..16). Any integer, not necessarily a power of two.
- CW, $clog2(DEPTH+1), width of the count output. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous discard of all buffered entries.
- s_valid  input  1  producer has a beat.
- s_ready  output  1  buffer can accept a beat.
- s_data  input  DW  producer payload.
- m_valid  output  1  head entry is valid.
- m_ready  input  1  consumer accepts the head entry.
- m_data  output  DW  head entry payload.
- count  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Handshakes:
  - Push when s_valid & s_ready at a clock edge.
  - Pop when m_valid & m_ready at a clock edge.
  - s_valid and s_data are sampled only on a push.
- Outputs are registered functions of state only:
  - s_ready = (count < DEPTH).
  - m_valid = (count != 0).
  - No combinational path from m_ready to s_ready, or from s_valid to m_valid.
- Latency: a beat pushed at edge N is presented with m_valid=1 after edge N. There is no same-cycle fall-through.
- Ordering: strict FIFO. m_data always shows the oldest entry.
- m_data = 0 whenever m_valid=0. It is never X.
- Storage: circular buffer with read/write pointers.
  - Pointers wrap from DEPTH-1 to 0. This is an explicit compare, not a modulo-2^k wrap, so non-power-of-two DEPTH works.
  - count is updated as +1 (push only), -1 (pop only), or unchanged (both or neither).
- Full (count==DEPTH): s_ready=0. A pop in this cycle does not enable a push in the same cycle; s_ready rises after the edge.
- Empty (count==0): m_valid=0 and m_ready is ignored.
- Push and pop in the same cycle with 0<count<DEPTH: count is unchanged and both pointers advance.
- Throughput:
  - DEPTH=1 sustains 1 beat per 2 cycles, matching the legacy IDLE/WAIT_READY behaviour.
  - DEPTH>=2 sustains 1 beat per cycle with continuous s_valid and m_ready.
- Flush (flush=1 at an edge):
  - After the edge: count=0, both pointers=0, m_valid=0, s_ready=1.
  - A pop in the flush cycle counts as completed, because the consumer saw it.
  - A push in the flush cycle is discarded.
  - flush has priority over push and pop.
- Reset (rst=1 at an edge, including mid-stream):
  - Same state as flush: count=0, m_valid=0, s_ready=1, m_data=0.
  - Storage contents need not be cleared.
  - rst has priority over flush.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - perf_xfer (32): increments on every pop.
  - perf_stall (32): increments every cycle with m_valid=1 & m_ready=0.
- Both counters are cleared by rst only; flush does not affect them.
- Both wrap from 0xFFFFFFFF to 0.
- When the macro is undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset/idle, DEPTH=2, DW=32: hold rst 2 cycles, release -> s_ready=1, m_valid=0, m_data=0, count=0. m_ready=1 with an empty buffer leaves count=0.
- Streaming, DEPTH=2: push 0x11..0x18 on consecutive cycles with m_ready=1 -> m_data sequence 0x11..0x18 in order, one per cycle starting 1 cycle after the first push, s_ready never deasserts.
- Backpressure, DEPTH=3: push 0xA, 0xB, 0xC with m_ready=0 -> count=3, s_ready=0. Push attempt 0xD ignored. Then m_ready=1 for 3 cycles -> outputs 0xA, 0xB, 0xC, then count=0.
- Full with pop, DEPTH=2: while full, assert m_ready=1 and s_valid=1 (0x55) in the same cycle -> pop occurs, 0x55 not accepted that cycle, s_ready=1 next cycle, 0x55 accepted one cycle later.
- Flush, DEPTH=4: buffer holds 3 entries, assert flush with s_valid=1 (0x77) -> next cycle count=0, m_valid=0, s_ready=1, 0x77 never appears on m_data.
- DEPTH=1 plus PIPE_STAGE_PERF_CNT_EN:
  - Continuous s_valid with m_ready=1 for 10 cycles -> 5 transfers, alternating m_valid.
  - Then hold m_ready=0 for 4 cycles with m_valid=1 -> perf_stall increases by 4.
  - perf_xfer equals the number of pops.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Parametrised valid/ready pipeline stage buffer: DEPTH-entry in-order queue with flush and occupancy.
// Optional perf counters (perf_xfer, perf_stall) are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_buf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] count
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]   perf_xfer,
  output logic [31:0]   perf_stall
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          push;
  logic          pop;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next-state for pointers, occupancy, storage and the registered handshake outputs.
  always_comb begin
    push     = s_valid & s_ready_q;
    pop      = m_valid_q & m_ready;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    s_ready_d = (count_d < CW'(DEPTH));
    m_valid_d = (count_d != '0);
    // Reading mem_d picks up a beat written this cycle into an empty queue.
    m_data_d  = m_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign count   = count_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] perf_xfer_q, perf_xfer_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Counters survive flush and wrap naturally at 32 bits.
  always_comb begin
    perf_xfer_d  = perf_xfer_q + 32'(pop);
    perf_stall_d = perf_stall_q + 32'(m_valid_q & ~m_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_xfer_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_xfer_q  <= perf_xfer_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_xfer  = perf_xfer_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: four depths (2,3,4,1) share one stimulus stream
// and are checked against queue-based models of the buffer's occupancy and ordering rules.
module tb_pipe_stage_buf;

  typedef logic [31:0] word_q_t[$];
  localparam int DEP [4] = '{2, 3, 4, 1};

  logic        clk = 1'b0;
  logic        rst, flush, s_valid, m_ready;
  logic [31:0] s_data;

  logic        sr [4];
  logic        mv [4];
  logic [31:0] md [4];
  int          cn [4];
  logic [1:0]  cnt_d2, cnt_d3;
  logic [2:0]  cnt_d4;
  logic [0:0]  cnt_d1;
  logic [31:0] px [4];
  logic [31:0] ps [4];

  word_q_t     mq [4];
  logic [31:0] exp_xfer  [4];
  logic [31:0] exp_stall [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign cn[0] = int'(cnt_d2);
  assign cn[1] = int'(cnt_d3);
  assign cn[2] = int'(cnt_d4);
  assign cn[3] = int'(cnt_d1);

  pipe_stage_buf #(.DW(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[0]), .s_data(s_data),
    .m_valid(mv[0]), .m_ready(m_ready), .m_data(md[0]), .count(cnt_d2)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .perf_xfer(px[0]), .perf_stall(ps[0])
`endif
  );
  pipe_stage_buf #(.DW(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[1]), .s_data(s_data),
    .m_valid(mv[1]), .m_ready(m_ready), .m_data(md[1]), .count(cnt_d3)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .perf_xfer(px[1]), .perf_stall(ps[1])
`endif
  );
  pipe_stage_buf #(.DW(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[2]), .s_data(s_data),
    .m_valid(mv[2]), .m_ready(m_ready), .m_data(md[2]), .count(cnt_d4)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .perf_xfer(px[2]), .perf_stall(ps[2])
`endif
  );
  pipe_stage_buf #(.DW(32), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(sr[3]), .s_data(s_data),
    .m_valid(mv[3]), .m_ready(m_ready), .m_data(md[3]), .count(cnt_d1)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .perf_xfer(px[3]), .perf_stall(ps[3])
`endif
  );

  // Advance one clock edge and apply the buffer rules to the reference queues.
  task automatic step();
    bit do_pop  [4];
    bit do_push [4];
    bit stall   [4];
    for (int i = 0; i < 4; i++) begin
      do_pop[i]  = (mq[i].size() != 0) && m_ready;
      do_push[i] = s_valid && (mq[i].size() < DEP[i]);
      stall[i]   = (mq[i].size() != 0) && !m_ready;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mq[i].delete();
        exp_xfer[i]  = 32'd0;
        exp_stall[i] = 32'd0;
      end else begin
        if (do_pop[i]) exp_xfer[i] = exp_xfer[i] + 32'd1;
        if (stall[i])  exp_stall[i] = exp_stall[i] + 32'd1;
        if (flush) mq[i].delete();
        else begin
          if (do_pop[i])  void'(mq[i].pop_front());
          if (do_push[i]) mq[i].push_back(s_data);
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 32'd0;
  endtask

  task automatic clear_all();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    step(); step();
    rst = 1'b0; s_valid = 1'b0;
    total++;
    if (sr[0] !== 1'b1 || mv[0] !== 1'b0 || md[0] !== 32'd0 || cn[0] !== 0) begin
      bad++;
      $display("FAIL reset_state: s_ready=%b m_valid=%b m_data=%h count=%0d, want 1 0 0 0",
               sr[0], mv[0], md[0], cn[0]);
    end
    m_ready = 1'b1;
    step();
    total++;
    if (cn[0] !== 0 || mv[0] !== 1'b0) begin
      bad++;
      $display("FAIL empty_pop: count=%0d m_valid=%b, want 0 0", cn[0], mv[0]);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_streaming();
    clear_all();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 32'h11 + 32'(i);
      step();
      total++;
      if (mv[0] !== 1'b1 || md[0] !== 32'h11 + 32'(i) || sr[0] !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d: m_valid=%b m_data=%h s_ready=%b, want 1 %h 1",
                 i, mv[0], md[0], sr[0], 32'h11 + 32'(i));
      end
    end
    s_valid = 1'b0;
    step();
    total++;
    if (mv[0] !== 1'b0 || cn[0] !== 0) begin
      bad++;
      $display("FAIL stream_drain: m_valid=%b count=%0d, want 0 0", mv[0], cn[0]);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3];
    want[0] = 32'hA; want[1] = 32'hB; want[2] = 32'hC;
    clear_all();
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = want[i];
      step();
    end
    total++;
    if (cn[1] !== 3 || sr[1] !== 1'b0 || md[1] !== 32'hA) begin
      bad++;
      $display("FAIL bp_full: count=%0d s_ready=%b m_data=%h, want 3 0 a", cn[1], sr[1], md[1]);
    end
    s_data = 32'hD;
    step();
    total++;
    if (cn[1] !== 3 || md[1] !== 32'hA) begin
      bad++;
      $display("FAIL bp_reject: count=%0d m_data=%h, want 3 a", cn[1], md[1]);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mv[1] !== 1'b1 || md[1] !== want[i]) begin
        bad++;
        $display("FAIL bp_out_%0d: m_valid=%b m_data=%h, want 1 %h", i, mv[1], md[1], want[i]);
      end
      step();
    end
    total++;
    if (cn[1] !== 0 || mv[1] !== 1'b0 || md[1] !== 32'd0) begin
      bad++;
      $display("FAIL bp_empty: count=%0d m_valid=%b m_data=%h, want 0 0 0", cn[1], mv[1], md[1]);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    clear_all();
    s_valid = 1'b1;
    s_data = 32'h33; step();
    s_data = 32'h44; step();
    total++;
    if (cn[0] !== 2 || sr[0] !== 1'b0) begin
      bad++;
      $display("FAIL fp_full: count=%0d s_ready=%b, want 2 0", cn[0], sr[0]);
    end
    s_data = 32'h55; m_ready = 1'b1;
    step();
    total++;
    if (cn[0] !== 1 || sr[0] !== 1'b1 || md[0] !== 32'h44) begin
      bad++;
      $display("FAIL fp_pop: count=%0d s_ready=%b m_data=%h, want 1 1 44", cn[0], sr[0], md[0]);
    end
    m_ready = 1'b0;
    step();
    total++;
    if (cn[0] !== 2 || md[0] !== 32'h44) begin
      bad++;
      $display("FAIL fp_accept: count=%0d m_data=%h, want 2 44", cn[0], md[0]);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    step();
    total++;
    if (md[0] !== 32'h55 || cn[0] !== 1) begin
      bad++;
      $display("FAIL fp_order: m_data=%h count=%0d, want 55 1", md[0], cn[0]);
    end
    step();
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    clear_all();
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 32'(i);
      step();
    end
    total++;
    if (cn[2] !== 3) begin
      bad++;
      $display("FAIL fl_fill: count=%0d, want 3", cn[2]);
    end
    flush = 1'b1; s_data = 32'h77;
    step();
    flush = 1'b0; s_valid = 1'b0;
    total++;
    if (cn[2] !== 0 || mv[2] !== 1'b0 || sr[2] !== 1'b1 || md[2] !== 32'd0) begin
      bad++;
      $display("FAIL fl_state: count=%0d m_valid=%b s_ready=%b m_data=%h, want 0 0 1 0",
               cn[2], mv[2], sr[2], md[2]);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mv[2] || md[2] == 32'h77) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL fl_discard: flushed beat visible=%b, want 0", seen);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_depth1_perf();
    int pops = 0;
    logic [31:0] base_x, base_s;
    clear_all();
    base_x = exp_xfer[3];
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 32'h100 + 32'(i);
      if (mv[3] === 1'b1) pops++;
      step();
      total++;
      if (mv[3] !== ((i % 2) == 0)) begin
        bad++;
        $display("FAIL d1_alt_%0d: m_valid=%b, want %b", i, mv[3], (i % 2) == 0);
      end
    end
    total++;
    if (pops != 5) begin
      bad++;
      $display("FAIL d1_xfers: pops=%0d, want 5", pops);
    end
`ifdef PIPE_STAGE_PERF_CNT_EN
    total++;
    if (px[3] !== base_x + 32'd5) begin
      bad++;
      $display("FAIL d1_perf_xfer: got %0d, want %0d", px[3], base_x + 32'd5);
    end
`endif
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    base_s = exp_stall[3];
    for (int i = 0; i < 4; i++) step();
    total++;
    if (mv[3] !== 1'b1) begin
      bad++;
      $display("FAIL d1_hold: m_valid=%b, want 1", mv[3]);
    end
`ifdef PIPE_STAGE_PERF_CNT_EN
    total++;
    if (ps[3] !== base_s + 32'd4) begin
      bad++;
      $display("FAIL d1_perf_stall: got %0d, want %0d", ps[3], base_s + 32'd4);
    end
`endif
    if (base_x == 32'hFFFF_FFFF && base_s == 32'hFFFF_FFFF) $display("note: counter bases saturated");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data  = $urandom;
      flush   = ($urandom_range(0, 23) == 0);
      rst     = ($urandom_range(0, 79) == 0);
      step();
      for (int i = 0; i < 4; i++) begin
        logic [31:0] want_d;
        want_d = (mq[i].size() != 0) ? mq[i][0] : 32'd0;
        total++;
        if (cn[i] !== mq[i].size() || mv[i] !== (mq[i].size() != 0) ||
            sr[i] !== (mq[i].size() < DEP[i]) || md[i] !== want_d) begin
          bad++;
          $display("FAIL rand_d%0d_n%0d: count=%0d m_valid=%b s_ready=%b m_data=%h, want %0d %b %b %h",
                   DEP[i], n, cn[i], mv[i], sr[i], md[i], mq[i].size(),
                   mq[i].size() != 0, mq[i].size() < DEP[i], want_d);
        end
`ifdef PIPE_STAGE_PERF_CNT_EN
        total++;
        if (px[i] !== exp_xfer[i] || ps[i] !== exp_stall[i]) begin
          bad++;
          $display("FAIL rand_perf_d%0d_n%0d: xfer=%0d stall=%0d, want %0d %0d",
                   DEP[i], n, px[i], ps[i], exp_xfer[i], exp_stall[i]);
        end
`endif
      end
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      exp_xfer[i]  = 32'd0;
      exp_stall[i] = 32'd0;
    end
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_depth1_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
